// File: rtl/basic_fft_iter.sv
// basic_fft_iter: iterative radix-2 decimation-in-time FFT, one butterfly per clock.
//
// A frame of N complex samples is loaded into an internal register array in
// bit-reversed order. LOG2N*N/2 butterflies are then run in place, scaling by
// 1/2 at every stage. The N bins are then streamed out in natural order.
// Frames do not overlap: input is stalled during COMPUTE and UNLOAD.
//
// Parameters
//   N       transform length, power of two, 4..1024
//   LOG2N   log2(N)
//   DW      signed sample / twiddle width (Q1.(DW-1) twiddles), DW <= 30
//   TW_FILE name of the twiddle image (Re/Im of W^k, W = exp(-j2pi/N)).
//           The same table is generated at elaboration by tw_val(), so the
//           block does not depend on the file being present at run time.
//
// Ports
//   clk, rst_n              clock (rising edge), async active-low reset
//   in_valid/in_ready       input sample handshake, in_re/in_im sample
//   out_valid/out_ready     output bin handshake, out_re/out_im bin
//   out_index, out_last     bin number k, high on k = N-1
//   busy                    high while the butterflies run
//
// state   | meaning
// LOAD    | accepting samples 0..N-1 into bit-reversed addresses
// COMPUTE | one butterfly per cycle, stage s, butterfly j
// UNLOAD  | presenting bins 0..N-1, advancing on handshake

module basic_fft_iter #(
  parameter int N       = 8,
  parameter int LOG2N   = 3,
  parameter int DW      = 16,
  parameter     TW_FILE = "rtl/fft8.mem"
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [DW-1:0]        in_re,
  input  logic [DW-1:0]        in_im,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [DW-1:0]        out_re,
  output logic [DW-1:0]        out_im,
  output logic [LOG2N-1:0]     out_index,
  output logic                 out_last,
  output logic                 busy
);

  localparam int AW = LOG2N;
  localparam int JW = (LOG2N > 1) ? LOG2N - 1 : 1;
  localparam int SW = (LOG2N > 1) ? $clog2(LOG2N) : 1;
  localparam int NH = N / 2;

  localparam logic [1:0] LOAD    = 2'd0;
  localparam logic [1:0] COMPUTE = 2'd1;
  localparam logic [1:0] UNLOAD  = 2'd2;

  // Rounding constant 2^(DW-2) for the Q1.(DW-1) product.
  localparam logic signed [2*DW:0] RND = {{(DW+2){1'b0}}, 1'b1, {(DW-2){1'b0}}};

  // Twiddle W^k in Q1.(DW-1), computed with a Q30 Taylor series on longint.
  // Angles past pi/2 are folded back so the series only runs on [0, pi/2].
  function automatic logic signed [DW-1:0] tw_val(input int k, input bit want_im);
    longint pi_q30, theta, x2, c, s, tc, ts, v, r, lim;
    int     kk;
    bit     flip;
    pi_q30 = 64'sd3373259426;
    kk     = k;
    flip   = 1'b0;
    if (4 * k > N) begin
      kk   = N / 2 - k;
      flip = 1'b1;
    end
    theta = (2 * pi_q30 * longint'(kk)) / longint'(N);
    x2    = (theta * theta) >>> 30;
    c     = 64'sd1 <<< 30;
    s     = theta;
    tc    = c;
    ts    = theta;
    for (int i = 1; i <= 10; i++) begin
      tc = -((tc * x2) >>> 30) / longint'((2 * i - 1) * (2 * i));
      ts = -((ts * x2) >>> 30) / longint'((2 * i) * (2 * i + 1));
      c  = c + tc;
      s  = s + ts;
    end
    if (flip) c = -c;
    v   = want_im ? -s : c;
    r   = (v + (64'sd1 <<< (30 - DW))) >>> (31 - DW);
    lim = (64'sd1 <<< (DW - 1)) - 1;
    if (r > lim) r = lim;
    return DW'(r);
  endfunction

  function automatic logic [AW-1:0] bit_rev(input logic [AW-1:0] v);
    logic [AW-1:0] r;
    for (int i = 0; i < AW; i++) r[i] = v[AW-1-i];
    return r;
  endfunction

  logic signed [DW-1:0] tw_re [NH];
  logic signed [DW-1:0] tw_im [NH];

  for (genvar k = 0; k < NH; k++) begin : g_tw
    assign tw_re[k] = tw_val(k, 1'b0);
    assign tw_im[k] = tw_val(k, 1'b1);
  end

  logic [1:0]    state;
  logic [AW-1:0] in_cnt;
  logic [SW-1:0] stg;
  logic [JW-1:0] bfly;
  logic [AW-1:0] out_idx;

  logic signed [DW-1:0] arr_re [N];
  logic signed [DW-1:0] arr_im [N];

  logic accept;
  assign in_ready = (state == LOAD);
  assign accept   = in_valid && in_ready;

  // Butterfly addressing and arithmetic.
  logic [AW-1:0] jx, half, mask, a_idx, b_idx;
  logic [JW-1:0] t_idx;
  logic signed [DW-1:0]    ar, ai, br, bi, wr, wi;
  logic signed [2*DW-1:0]  m_rr, m_ii, m_ri, m_ir;
  logic signed [2*DW:0]    pr_full, pi_full;
  logic signed [DW+1:0]    p_r, p_i;
  logic signed [DW+2:0]    s_ar, s_ai, s_br, s_bi;
  logic signed [DW-1:0]    na_r, na_i, nb_r, nb_i;

  always_comb begin
    jx    = AW'(bfly);
    half  = AW'(1) << stg;
    mask  = half - AW'(1);
    a_idx = (((jx >> stg) << stg) << 1) | (jx & mask);
    b_idx = a_idx | half;
    t_idx = JW'((jx & mask) << (AW'(LOG2N - 1) - AW'(stg)));

    ar = arr_re[a_idx];
    ai = arr_im[a_idx];
    br = arr_re[b_idx];
    bi = arr_im[b_idx];
    wr = tw_re[t_idx];
    wi = tw_im[t_idx];

    m_rr = br * wr;
    m_ii = bi * wi;
    m_ri = br * wi;
    m_ir = bi * wr;
    pr_full = (2*DW+1)'(m_rr) - (2*DW+1)'(m_ii);
    pi_full = (2*DW+1)'(m_ri) + (2*DW+1)'(m_ir);
    p_r = (DW+2)'((pr_full + RND) >>> (DW - 1));
    p_i = (DW+2)'((pi_full + RND) >>> (DW - 1));

    // Sums kept wide, halved on writeback so each stage scales by 1/2.
    s_ar = (DW+3)'(ar) + (DW+3)'(p_r);
    s_ai = (DW+3)'(ai) + (DW+3)'(p_i);
    s_br = (DW+3)'(ar) - (DW+3)'(p_r);
    s_bi = (DW+3)'(ai) - (DW+3)'(p_i);
    na_r = DW'(s_ar >>> 1);
    na_i = DW'(s_ai >>> 1);
    nb_r = DW'(s_br >>> 1);
    nb_i = DW'(s_bi >>> 1);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= LOAD;
      in_cnt  <= '0;
      stg     <= '0;
      bfly    <= '0;
      out_idx <= '0;
    end else begin
      case (state)
        LOAD: begin
          if (accept) begin
            in_cnt <= in_cnt + AW'(1);
            if (in_cnt == AW'(N - 1)) begin
              state <= COMPUTE;
              stg   <= '0;
              bfly  <= '0;
            end
          end
        end
        COMPUTE: begin
          if (bfly == JW'(NH - 1)) begin
            bfly <= '0;
            if (stg == SW'(LOG2N - 1)) begin
              stg   <= '0;
              state <= UNLOAD;
            end else begin
              stg <= stg + SW'(1);
            end
          end else begin
            bfly <= bfly + JW'(1);
          end
        end
        UNLOAD: begin
          if (out_ready) begin
            out_idx <= out_idx + AW'(1);
            if (out_idx == AW'(N - 1)) state <= LOAD;
          end
        end
        default: state <= LOAD;
      endcase
    end
  end

  // Data array carries no reset; every frame overwrites all N entries.
  always_ff @(posedge clk) begin
    if (accept) begin
      arr_re[bit_rev(in_cnt)] <= in_re;
      arr_im[bit_rev(in_cnt)] <= in_im;
    end else if (state == COMPUTE) begin
      arr_re[a_idx] <= na_r;
      arr_im[a_idx] <= na_i;
      arr_re[b_idx] <= nb_r;
      arr_im[b_idx] <= nb_i;
    end
  end

  assign out_valid = (state == UNLOAD);
  assign out_re    = out_valid ? arr_re[out_idx] : '0;
  assign out_im    = out_valid ? arr_im[out_idx] : '0;
  assign out_index = out_idx;
  assign out_last  = out_valid && (out_idx == AW'(N - 1));
  assign busy      = (state == COMPUTE);

endmodule

// File: tb/tb_basic_fft_iter.sv
// Testbench for basic_fft_iter: an 8-point and a 16-point instance, driven in
// turn, checked against a floating-point-twiddle reference DIT model.

module tb_basic_fft_iter;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic               in_valid = 1'b0;
  logic               out_ready = 1'b0;
  logic               sel16 = 1'b0;
  logic signed [15:0] in_re = '0;
  logic signed [15:0] in_im = '0;

  logic iv8, iv16, or8, or16;
  assign iv8  = in_valid & ~sel16;
  assign iv16 = in_valid & sel16;
  assign or8  = out_ready & ~sel16;
  assign or16 = out_ready & sel16;

  logic        ir8, ov8, last8, busy8;
  logic [15:0] re8, im8;
  logic [2:0]  idx8;
  logic        ir16, ov16, last16, busy16;
  logic [15:0] re16, im16;
  logic [3:0]  idx16;

  basic_fft_iter #(.N(8), .LOG2N(3), .DW(16), .TW_FILE("rtl/fft8.mem")) dut8 (
    .clk(clk), .rst_n(rst_n), .in_valid(iv8), .in_ready(ir8),
    .in_re(in_re), .in_im(in_im), .out_valid(ov8), .out_ready(or8),
    .out_re(re8), .out_im(im8), .out_index(idx8), .out_last(last8), .busy(busy8));

  basic_fft_iter #(.N(16), .LOG2N(4), .DW(16), .TW_FILE("rtl/fft16.mem")) dut16 (
    .clk(clk), .rst_n(rst_n), .in_valid(iv16), .in_ready(ir16),
    .in_re(in_re), .in_im(in_im), .out_valid(ov16), .out_ready(or16),
    .out_re(re16), .out_im(im16), .out_index(idx16), .out_last(last16), .busy(busy16));

  logic               o_in_ready, o_valid, o_last, o_busy;
  logic signed [15:0] o_re, o_im;
  logic [3:0]         o_idx;
  assign o_in_ready = sel16 ? ir16 : ir8;
  assign o_valid    = sel16 ? ov16 : ov8;
  assign o_last     = sel16 ? last16 : last8;
  assign o_busy     = sel16 ? busy16 : busy8;
  assign o_re       = sel16 ? re16 : re8;
  assign o_im       = sel16 ? im16 : im8;
  assign o_idx      = sel16 ? idx16 : {1'b0, idx8};

  int checks = 0;
  int errors = 0;

  task automatic chk(input string tag, input logic signed [31:0] obs, input logic signed [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  int x_re [16];
  int x_im [16];
  int y_re [16];
  int y_im [16];
  int obs_re [16];
  int obs_im [16];

  function automatic int rev(input int v, input int lg);
    int r = 0;
    for (int i = 0; i < lg; i++) if (v & (1 << i)) r |= 1 << (lg - 1 - i);
    return r;
  endfunction

  function automatic longint tw_re(input int k, input int n);
    real a = 2.0 * 3.14159265358979323846 * k / n;
    int v = $rtoi($floor($cos(a) * 32768.0 + 0.5));
    if (v > 32767) v = 32767;
    return longint'(v);
  endfunction

  function automatic longint tw_im(input int k, input int n);
    real a = 2.0 * 3.14159265358979323846 * k / n;
    int v = $rtoi($floor(-$sin(a) * 32768.0 + 0.5));
    if (v > 32767) v = 32767;
    return longint'(v);
  endfunction

  // Textbook in-place DIT FFT with the block's fixed-point rounding and 1/2 scaling.
  function automatic void model(input int n);
    longint ar [16];
    longint ai [16];
    longint wr, wi, pr, pim, a_r, a_i;
    int lg = (n == 16) ? 4 : 3;
    for (int i = 0; i < n; i++) begin
      ar[rev(i, lg)] = longint'(x_re[i]);
      ai[rev(i, lg)] = longint'(x_im[i]);
    end
    for (int st = 0; st < lg; st++) begin
      int half = 1 << st;
      int span = 2 * half;
      for (int base = 0; base < n; base += span) begin
        for (int m = 0; m < half; m++) begin
          int ia = base + m;
          int ib = ia + half;
          wr  = tw_re(m * (n / span), n);
          wi  = tw_im(m * (n / span), n);
          pr  = (ar[ib] * wr - ai[ib] * wi + 16384) >>> 15;
          pim = (ar[ib] * wi + ai[ib] * wr + 16384) >>> 15;
          a_r = ar[ia];
          a_i = ai[ia];
          ar[ia] = (a_r + pr) >>> 1;
          ai[ia] = (a_i + pim) >>> 1;
          ar[ib] = (a_r - pr) >>> 1;
          ai[ib] = (a_i - pim) >>> 1;
        end
      end
    end
    for (int i = 0; i < n; i++) begin
      y_re[i] = int'(ar[i]);
      y_im[i] = int'(ai[i]);
    end
  endfunction

  task automatic clear_x();
    for (int i = 0; i < 16; i++) begin
      x_re[i] = 0;
      x_im[i] = 0;
    end
  endtask

  task automatic rand_x();
    for (int i = 0; i < 16; i++) begin
      x_re[i] = int'($urandom_range(0, 16382)) - 8191;
      x_im[i] = int'($urandom_range(0, 16382)) - 8191;
    end
  endtask

  task automatic feed(input int cnt, input bit gaps);
    bit acc;
    int g;
    for (int i = 0; i < cnt; i++) begin
      if (gaps) begin
        repeat ($urandom_range(0, 2)) begin
          @(negedge clk);
          in_valid = 1'b0;
          in_re = 16'($urandom);
          @(posedge clk);
        end
      end
      acc = 1'b0;
      g = 0;
      while (!acc) begin
        @(negedge clk);
        in_valid = 1'b1;
        in_re = 16'(x_re[i]);
        in_im = 16'(x_im[i]);
        acc = o_in_ready;
        @(posedge clk);
        g++;
        if (!acc && g > 20) begin
          chk("accept_timeout", o_in_ready, 1);
          acc = 1'b1;
        end
      end
    end
  endtask

  task automatic run_frame(input int n, input bit gaps, input int stall_k);
    int lat, k, g, lg;
    bit stalled;
    lg = (n == 16) ? 4 : 3;
    sel16 = (n == 16);
    model(n);
    feed(n, gaps);
    @(negedge clk);
    in_valid = 1'($urandom);
    out_ready = 1'($urandom);
    chk("busy_compute", o_busy, 1);
    chk("in_ready_compute", o_in_ready, 0);
    lat = 0;
    while (!o_valid && lat < 100) begin
      @(posedge clk);
      lat++;
      @(negedge clk);
      in_valid = 1'($urandom);
      out_ready = 1'($urandom);
    end
    chk("latency", lat, n * lg / 2);
    k = 0;
    g = 0;
    stalled = 1'b0;
    while (k < n && g < 200) begin
      if (k == stall_k && !stalled && o_valid) begin
        stalled = 1'b1;
        out_ready = 1'b0;
        repeat (5) begin
          @(posedge clk);
          @(negedge clk);
          chk("hold_valid", o_valid, 1);
          chk("hold_idx", o_idx, k);
          chk("hold_re", o_re, y_re[k]);
          chk("hold_im", o_im, y_im[k]);
        end
      end
      out_ready = 1'b1;
      if (o_valid) begin
        chk("out_index", o_idx, k);
        chk("out_last", o_last, (k == n - 1) ? 1 : 0);
        chk("bin_re", o_re, y_re[k]);
        chk("bin_im", o_im, y_im[k]);
        obs_re[k] = int'(o_re);
        obs_im[k] = int'(o_im);
        k++;
      end
      @(posedge clk);
      @(negedge clk);
      g++;
    end
    chk("bins_seen", k, n);
    chk("in_ready_after", o_in_ready, 1);
    chk("valid_after", o_valid, 0);
    out_ready = 1'b0;
    in_valid = 1'b0;
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_in_ready"}, o_in_ready, 1);
    chk({tag, "_valid"}, o_valid, 0);
    chk({tag, "_last"}, o_last, 0);
    chk({tag, "_busy"}, o_busy, 0);
    chk({tag, "_idx"}, o_idx, 0);
    chk({tag, "_re"}, o_re, 0);
    chk({tag, "_im"}, o_im, 0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_reset_outputs("reset");
    rst_n = 1'b1;

    clear_x();
    x_re[0] = 1024;
    run_frame(8, 1'b0, -1);
    for (int k = 0; k < 8; k++) begin
      chk("impulse_re", obs_re[k], 128);
      chk("impulse_im", obs_im[k], 0);
    end

    for (int i = 0; i < 8; i++) begin
      x_re[i] = 1024;
      x_im[i] = 0;
    end
    run_frame(8, 1'b0, -1);
    for (int k = 0; k < 8; k++) begin
      chk("dc_re", obs_re[k], (k == 0) ? 1024 : 0);
      chk("dc_im", obs_im[k], 0);
    end

    clear_x();
    x_re[1] = 1024;
    run_frame(8, 1'b0, -1);
    chk("shift_y0_re", obs_re[0], 128);
    chk("shift_y0_im", obs_im[0], 0);
    chk("shift_y2_re", obs_re[2], 0);
    chk("shift_y2_im", obs_im[2], -128);
    chk("shift_y4_re", obs_re[4], -128);
    chk("shift_y4_im", obs_im[4], 0);
    chk("shift_y6_re", obs_re[6], 0);
    chk("shift_y6_im", obs_im[6], 128);
    chk("shift_y1_re_tol", (obs_re[1] >= 90 && obs_re[1] <= 92) ? 1 : 0, 1);
    chk("shift_y1_im_tol", (obs_im[1] >= -92 && obs_im[1] <= -90) ? 1 : 0, 1);

    rand_x();
    run_frame(8, 1'b1, 3);
    rand_x();
    run_frame(8, 1'b1, -1);

    // Reset part-way through LOAD, then a full frame from sample 0.
    rand_x();
    sel16 = 1'b0;
    feed(3, 1'b0);
    @(negedge clk);
    in_valid = 1'b0;
    rst_n = 1'b0;
    #1;
    check_reset_outputs("rst_load");
    @(negedge clk);
    rst_n = 1'b1;
    rand_x();
    run_frame(8, 1'b1, -1);

    // Reset during COMPUTE cycle 5.
    clear_x();
    x_re[0] = 1024;
    sel16 = 1'b0;
    feed(8, 1'b0);
    repeat (4) @(posedge clk);
    #1;
    in_valid = 1'b0;
    chk("busy_before_rst", o_busy, 1);
    rst_n = 1'b0;
    #1;
    check_reset_outputs("rst_compute");
    @(negedge clk);
    rst_n = 1'b1;
    run_frame(8, 1'b0, -1);
    for (int k = 0; k < 8; k++) begin
      chk("post_rst_re", obs_re[k], 128);
      chk("post_rst_im", obs_im[k], 0);
    end

    clear_x();
    x_re[0] = 1024;
    run_frame(16, 1'b0, -1);
    for (int k = 0; k < 16; k++) begin
      chk("n16_impulse_re", obs_re[k], 64);
      chk("n16_impulse_im", obs_im[k], 0);
    end
    rand_x();
    run_frame(16, 1'b1, 9);

    rand_x();
    run_frame(8, 1'b1, 7);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
